// File: rtl/vga_fifo_ext_if.sv
// Handshake and status bundle between the VGA FIFO and its producer/consumer.
// The master side drives requests and write data; the slave side is the FIFO.
interface vga_fifo_ext_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 6,
    parameter int CW    = $clog2(DEPTH + 1)
);
    logic             flush;
    logic             push;
    logic [WIDTH-1:0] din;
    logic             pop;
    logic             err_clr;
    logic [WIDTH-1:0] dout;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output flush, push, din, pop, err_clr,
        input  dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, push, din, pop, err_clr,
        output dout, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/vga_fifo_ext.sv
// Show-ahead FIFO, any depth >= 2, with occupancy count, threshold flags, flush and sticky errors.
// dout has zero read latency; flags decode from the registered count; a push while full is taken only with a pop.
module vga_fifo_ext #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 6,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 2,
    parameter int CW        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    vga_fifo_ext_if.slave      bus
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             full, empty, wen, ren;

    always_comb begin
        full  = (count_q == CW'(DEPTH));
        empty = (count_q == '0);
        wen   = bus.push & (~full | bus.pop);
        ren   = bus.pop & ~empty;

        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        // Explicit wrap so non-power-of-two depths never alias.
        if (ren)
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (wen)
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (wen && !ren)
            count_d = count_q + 1'b1;
        else if (ren && !wen)
            count_d = count_q - 1'b1;

        if (bus.flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end

        // A new error in the same cycle as err_clr keeps the flag set.
        overflow_d  = (overflow_q  & ~bus.err_clr) | (bus.push & full & ~bus.pop & ~bus.flush);
        underflow_d = (underflow_q & ~bus.err_clr) | (bus.pop & empty & ~bus.flush);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !bus.flush && wen)
            mem[wr_ptr_q] <= bus.din;
    end

    assign bus.dout         = mem[rd_ptr_q];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CW'(AFULL_TH));
    assign bus.almost_empty = (count_q <= CW'(AEMPTY_TH));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_vga_fifo_ext.sv
// Directed and model-checked bench for vga_fifo_ext at DEPTH=6.
module tb_vga_fifo_ext;
    localparam int WIDTH = 32;
    localparam int DEPTH = 6;
    localparam int CW    = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    vga_fifo_ext_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CW(CW)) bus ();

    vga_fifo_ext #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.flush = 0; bus.push = 0; bus.pop = 0; bus.err_clr = 0; bus.din = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1; step(); step();
        reset = 0; step();
        n_total++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %0b want 1", bus.empty); else n_pass++;
        n_total++; if (bus.full !== 1'b0) $display("FAIL reset_full got %0b want 0", bus.full); else n_pass++;
        n_total++; if (bus.count !== 3'd0) $display("FAIL reset_count got %0d want 0", bus.count); else n_pass++;
        n_total++; if (bus.almost_empty !== 1'b1) $display("FAIL reset_aempty got %0b want 1", bus.almost_empty); else n_pass++;
        n_total++; if (bus.almost_full !== 1'b0) $display("FAIL reset_afull got %0b want 0", bus.almost_full); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL reset_ovf got %0b want 0", bus.overflow); else n_pass++;
        n_total++; if (bus.underflow !== 1'b0) $display("FAIL reset_udf got %0b want 0", bus.underflow); else n_pass++;
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) begin
            bus.push = 1; bus.din = 32'h10 + i;
            step();
            n_total++; if (bus.count !== CW'(i + 1)) $display("FAIL fill_count got %0d want %0d", bus.count, i + 1); else n_pass++;
            n_total++; if (bus.almost_full !== (i + 1 >= 4)) $display("FAIL fill_afull at %0d got %0b want %0b", i + 1, bus.almost_full, (i + 1 >= 4)); else n_pass++;
            n_total++; if (bus.almost_empty !== (i + 1 <= 2)) $display("FAIL fill_aempty at %0d got %0b want %0b", i + 1, bus.almost_empty, (i + 1 <= 2)); else n_pass++;
        end
        bus.push = 0;
        n_total++; if (bus.full !== 1'b1) $display("FAIL fill_full got %0b want 1", bus.full); else n_pass++;
        for (int i = 0; i < DEPTH; i++) begin
            bus.pop = 1;
            n_total++; if (bus.dout !== 32'h10 + i) $display("FAIL drain_dout got %h want %h", bus.dout, 32'h10 + i); else n_pass++;
            step();
        end
        bus.pop = 0;
        n_total++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got %0b want 1", bus.empty); else n_pass++;
        n_total++; if (bus.underflow !== 1'b0) $display("FAIL drain_udf got %0b want 0", bus.underflow); else n_pass++;
    endtask

    task automatic test_full_passthrough();
        logic [WIDTH-1:0] exp_seq [DEPTH];
        for (int i = 0; i < DEPTH; i++) begin
            bus.push = 1; bus.din = 32'h10 + i; step();
        end
        bus.push = 1; bus.pop = 1; bus.din = 32'hAA;
        n_total++; if (bus.dout !== 32'h10) $display("FAIL pass_head got %h want 10", bus.dout); else n_pass++;
        step();
        n_total++; if (bus.count !== 3'd6) $display("FAIL pass_count got %0d want 6", bus.count); else n_pass++;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL pass_noovf got %0b want 0", bus.overflow); else n_pass++;
        bus.pop = 0; bus.din = 32'hBB;
        step();
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set got %0b want 1", bus.overflow); else n_pass++;
        n_total++; if (bus.count !== 3'd6) $display("FAIL ovf_count got %0d want 6", bus.count); else n_pass++;
        bus.err_clr = 1; bus.din = 32'hCC;
        step();
        n_total++; if (bus.overflow !== 1'b1) $display("FAIL ovf_set_wins got %0b want 1", bus.overflow); else n_pass++;
        bus.push = 0;
        step();
        bus.err_clr = 0;
        n_total++; if (bus.overflow !== 1'b0) $display("FAIL ovf_clr got %0b want 0", bus.overflow); else n_pass++;
        exp_seq = '{32'h11, 32'h12, 32'h13, 32'h14, 32'h15, 32'hAA};
        for (int i = 0; i < DEPTH; i++) begin
            bus.pop = 1;
            n_total++; if (bus.dout !== exp_seq[i]) $display("FAIL pass_order got %h want %h", bus.dout, exp_seq[i]); else n_pass++;
            step();
        end
        bus.pop = 0;
        n_total++; if (bus.empty !== 1'b1) $display("FAIL pass_empty got %0b want 1", bus.empty); else n_pass++;
    endtask

    task automatic test_underflow();
        bus.push = 1; bus.pop = 1; bus.din = 32'h55;
        step();
        bus.push = 0; bus.pop = 0;
        n_total++; if (bus.underflow !== 1'b1) $display("FAIL udf_set got %0b want 1", bus.underflow); else n_pass++;
        n_total++; if (bus.count !== 3'd1) $display("FAIL udf_count got %0d want 1", bus.count); else n_pass++;
        n_total++; if (bus.dout !== 32'h55) $display("FAIL udf_dout got %h want 55", bus.dout); else n_pass++;
    endtask

    task automatic test_flush();
        // Continues from one entry (0x55) with underflow still set.
        for (int i = 0; i < 2; i++) begin
            bus.push = 1; bus.din = 32'h60 + i; step();
        end
        n_total++; if (bus.count !== 3'd3) $display("FAIL flush_pre got %0d want 3", bus.count); else n_pass++;
        bus.flush = 1; bus.din = 32'h99;
        step();
        bus.flush = 0; bus.push = 0;
        n_total++; if (bus.count !== 3'd0) $display("FAIL flush_count got %0d want 0", bus.count); else n_pass++;
        n_total++; if (bus.empty !== 1'b1) $display("FAIL flush_empty got %0b want 1", bus.empty); else n_pass++;
        n_total++; if (bus.underflow !== 1'b1) $display("FAIL flush_keeps_udf got %0b want 1", bus.underflow); else n_pass++;
        bus.push = 1; bus.din = 32'h77;
        step();
        bus.push = 0;
        n_total++; if (bus.dout !== 32'h77) $display("FAIL flush_next got %h want 77", bus.dout); else n_pass++;
        n_total++; if (bus.count !== 3'd1) $display("FAIL flush_next_count got %0d want 1", bus.count); else n_pass++;
        bus.pop = 1; bus.err_clr = 1;
        step();
        bus.pop = 0; bus.err_clr = 0;
        n_total++; if (bus.underflow !== 1'b0) $display("FAIL udf_clr got %0b want 0", bus.underflow); else n_pass++;
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] q[$];
        logic p, r, w_ok;
        int   errs = 0;
        for (int c = 0; c < 3000; c++) begin
            p = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 45);
            bus.push = p; bus.pop = r; bus.din = $urandom;
            if (q.size() > 0 && errs < 10) begin
                n_total++;
                if (bus.dout !== q[0]) begin
                    $display("FAIL rand_dout cyc %0d got %h want %h", c, bus.dout, q[0]); errs++;
                end else n_pass++;
            end
            if (errs < 10) begin
                n_total++;
                if (bus.count !== CW'(q.size())) begin
                    $display("FAIL rand_count cyc %0d got %0d want %0d", c, bus.count, q.size()); errs++;
                end else n_pass++;
            end
            w_ok = p && (q.size() < DEPTH || r);
            if (r && q.size() > 0) void'(q.pop_front());
            if (w_ok) q.push_back(bus.din);
            step();
        end
        idle_inputs();
        n_total++; if (bus.count !== CW'(q.size())) $display("FAIL rand_final got %0d want %0d", bus.count, q.size()); else n_pass++;
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_full_passthrough();
        test_underflow();
        test_flush();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule
